game_controller: RTL



---
 rtl/game_controller_if.sv | 23 ++
 rtl/game_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/game_controller_if.sv
// Action handshake between the two player blocks and the game controller:
// offered actions with valid/ready, plus the registered actions and their apply strobe.
interface game_controller_if;
    logic       act1_valid;
    logic       act2_valid;
    logic [2:0] act1_in;
    logic [2:0] act2_in;
    logic       act1_ready;
    logic       act2_ready;
    logic [2:0] action1;
    logic [2:0] action2;
    logic       actionEnable;

    modport master (
        output act1_valid, act2_valid, act1_in, act2_in,
        input  act1_ready, act2_ready, action1, action2, actionEnable
    );

    modport slave (
        input  act1_valid, act2_valid, act1_in, act2_in,
        output act1_ready, act2_ready, action1, action2, actionEnable
    );
endinterface

// File: rtl/game_controller.sv
// Two-player turn controller: collects one action per player (forcing "await" on timeout),
// applies both together, then judges health to continue, declare a winner or end on turn limit.
module game_controller #(
    parameter int TIMEOUT   = 100,
    parameter int MAX_TURNS = 99
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         health1,
    input  logic [1:0]         health2,
    game_controller_if.slave   bus,
    output logic               player_reset,
    output logic               isGameOver,
    output logic [1:0]         winner,
    output logic [7:0]         turn_count,
    output logic               timed_out
);
    typedef enum logic [2:0] {IDLE, INIT, COLLECT, APPLY, CHECK, OVER} state_t;

    localparam logic [2:0]  AWAIT      = 3'b010;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [8:0]  TURN_LIMIT = 9'(MAX_TURNS);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        latched1_q, latched1_d;
    logic        latched2_q, latched2_d;
    logic [2:0]  action1_q, action1_d;
    logic [2:0]  action2_q, action2_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  turn_q, turn_d;
    logic        timed_out_q, timed_out_d;
    logic [8:0]  turn_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            latched1_q  <= 1'b0;
            latched2_q  <= 1'b0;
            action1_q   <= AWAIT;
            action2_q   <= AWAIT;
            winner_q    <= 2'b00;
            turn_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            latched1_q  <= latched1_d;
            latched2_q  <= latched2_d;
            action1_q   <= action1_d;
            action2_q   <= action2_d;
            winner_q    <= winner_d;
            turn_q      <= turn_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        latched1_d  = latched1_q;
        latched2_d  = latched2_q;
        action1_d   = action1_q;
        action2_d   = action2_q;
        winner_d    = winner_q;
        turn_d      = turn_q;
        timed_out_d = timed_out_q;
        turn_next   = {1'b0, turn_q} + 9'd1;

        case (state_q)
            IDLE, OVER: begin
                // Results are cleared on the way into INIT so they read zero during it.
                if (start) begin
                    state_d     = INIT;
                    winner_d    = 2'b00;
                    turn_d      = '0;
                    timer_d     = '0;
                    latched1_d  = 1'b0;
                    latched2_d  = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            INIT: state_d = COLLECT;
            COLLECT: begin
                if (bus.act1_valid && !latched1_q) begin
                    action1_d  = bus.act1_in;
                    latched1_d = 1'b1;
                end
                if (bus.act2_valid && !latched2_q) begin
                    action2_d  = bus.act2_in;
                    latched2_d = 1'b1;
                end
                timer_d = timer_q + 16'd1;
                // A valid arriving on the last timer cycle is already in latchedN_d, so it beats the forced await.
                if (latched1_d && latched2_d) begin
                    state_d = APPLY;
                end else if (timer_q == TIMER_LAST) begin
                    if (!latched1_d) action1_d = AWAIT;
                    if (!latched2_d) action2_d = AWAIT;
                    latched1_d  = 1'b1;
                    latched2_d  = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = APPLY;
                end
            end
            APPLY: state_d = CHECK;
            CHECK: begin
                turn_d = (turn_q == 8'hFF) ? turn_q : turn_next[7:0];
                if (health1 == 2'b00 && health2 == 2'b00) begin
                    winner_d = 2'b11;
                    state_d  = OVER;
                end else if (health1 == 2'b00) begin
                    winner_d = 2'b10;
                    state_d  = OVER;
                end else if (health2 == 2'b00) begin
                    winner_d = 2'b01;
                    state_d  = OVER;
                end else if (turn_next == TURN_LIMIT) begin
                    winner_d = (health1 > health2) ? 2'b01 :
                               (health1 < health2) ? 2'b10 : 2'b11;
                    state_d  = OVER;
                end else begin
                    latched1_d  = 1'b0;
                    latched2_d  = 1'b0;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.act1_ready   = (state_q == COLLECT) && !latched1_q;
    assign bus.act2_ready   = (state_q == COLLECT) && !latched2_q;
    assign bus.action1      = action1_q;
    assign bus.action2      = action2_q;
    assign bus.actionEnable = (state_q == APPLY);
    assign player_reset     = (state_q == INIT);
    assign isGameOver       = (state_q == OVER);
    assign winner           = winner_q;
    assign turn_count       = turn_q;
    assign timed_out        = timed_out_q;
endmodule
